// File: rtl/recovery_sequencer_if.sv
// Signal bundle between the recovery sequencer, the recovery datapath and the CSR block.
// The master modport is the sequencer's view.
interface recovery_sequencer_if #(
  parameter int MAX_RETRIES     = 3,
  parameter int VIOLATION_LIMIT = 8
);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int VW = $clog2(VIOLATION_LIMIT + 1);

  logic          start_i;
  logic          restart_i;
  logic          fault_ack_i;
  logic          fully_locked_i;
  logic          bandpass_over_i;
  logic          bandpass_under_i;
  logic          pos_drift_i;
  logic          neg_drift_i;
  logic          recovery_en_o;
  logic          clear_state_o;
  logic          locked_o;
  logic          fault_o;
  logic [2:0]    state_o;
  logic [RW-1:0] retry_count_o;
  logic [VW-1:0] violation_count_o;

  modport master (
    input  start_i, restart_i, fault_ack_i, fully_locked_i,
           bandpass_over_i, bandpass_under_i, pos_drift_i, neg_drift_i,
    output recovery_en_o, clear_state_o, locked_o, fault_o,
           state_o, retry_count_o, violation_count_o
  );

  modport slave (
    output start_i, restart_i, fault_ack_i, fully_locked_i,
           bandpass_over_i, bandpass_under_i, pos_drift_i, neg_drift_i,
    input  recovery_en_o, clear_state_o, locked_o, fault_o,
           state_o, retry_count_o, violation_count_o
  );
endinterface

// File: rtl/recovery_sequencer.sv
// Bring-up and supervision FSM for one clock-recovery instance:
// clear -> acquire -> locked, with exponential-backoff retries and a sticky fault.
module recovery_sequencer #(
  parameter int CLEAR_CYCLES    = 4,
  parameter int ACQ_TIMEOUT     = 4096,
  parameter int MAX_RETRIES     = 3,
  parameter int VIOLATION_LIMIT = 8,
  parameter int BACKOFF_BASE    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  recovery_sequencer_if.master bus
);
  localparam int RW     = $clog2(MAX_RETRIES + 1);
  localparam int VW     = $clog2(VIOLATION_LIMIT + 1);
  localparam int BO_MAX = BACKOFF_BASE << MAX_RETRIES;
  localparam int T_A    = (ACQ_TIMEOUT > CLEAR_CYCLES) ? ACQ_TIMEOUT : CLEAR_CYCLES;
  localparam int T_MAX  = (T_A > BO_MAX) ? T_A : BO_MAX;
  localparam int TW     = $clog2(T_MAX + 1);

  // Timer loads are length-1 so that a state lasts exactly its length in cycles.
  localparam logic [TW-1:0] CLEAR_LOAD = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] ACQ_LOAD   = TW'(ACQ_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_ZERO = {RW{1'b0}};
  localparam logic [VW-1:0] VIOL_LAST  = VW'(VIOLATION_LIMIT - 1);
  localparam logic [VW-1:0] VIOL_SAT   = VW'(VIOLATION_LIMIT);
  localparam logic [VW-1:0] VIOL_ZERO  = {VW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_BACKOFF = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [VW-1:0] viol_cnt_q, viol_cnt_d;
  logic          recovery_en_q, recovery_en_d;
  logic          clear_state_q, clear_state_d;
  logic          locked_q, locked_d;
  logic          fault_q, fault_d;

  state_e        fail_state_s;
  logic [RW-1:0] fail_retry_s;
  logic [TW-1:0] fail_timer_s;
  logic          viol_s;
  logic          in_run_s;

  // Backoff length for the attempt about to start; r is the pre-increment retry count.
  function automatic logic [TW-1:0] backoff_load(input logic [RW-1:0] r);
    return TW'((32'(BACKOFF_BASE) << r) - 32'd1);
  endfunction

  // Destination shared by every failure path (acquire timeout, loss of lock, violations).
  always_comb begin
    viol_s   = bus.bandpass_over_i | bus.bandpass_under_i | bus.pos_drift_i | bus.neg_drift_i;
    in_run_s = (state_q == ST_CLEAR) || (state_q == ST_ACQUIRE) ||
               (state_q == ST_LOCKED) || (state_q == ST_BACKOFF);
    if (retry_q < RETRY_MAX) begin
      fail_state_s = ST_BACKOFF;
      fail_retry_s = retry_q + RW'(1);
      fail_timer_s = backoff_load(retry_q);
    end else begin
      fail_state_s = ST_FAULT;
      fail_retry_s = retry_q;
      fail_timer_s = TIMER_ZERO;
    end
  end

  // Next-state, timer and counter update with stop > restart > per-state priority.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    viol_cnt_d = viol_cnt_q;
    if ((state_q != ST_FAULT) && !bus.start_i) begin
      state_d = ST_IDLE;
      timer_d = TIMER_ZERO;
    end else if (bus.restart_i && in_run_s) begin
      state_d    = ST_CLEAR;
      timer_d    = CLEAR_LOAD;
      retry_d    = RETRY_ZERO;
      viol_cnt_d = VIOL_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_CLEAR;
          timer_d    = CLEAR_LOAD;
          retry_d    = RETRY_ZERO;
          viol_cnt_d = VIOL_ZERO;
        end
        ST_CLEAR: begin
          if (timer_q == TIMER_ZERO) begin
            state_d = ST_ACQUIRE;
            timer_d = ACQ_LOAD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_ACQUIRE: begin
          if (bus.fully_locked_i) begin
            state_d = ST_LOCKED;
            timer_d = TIMER_ZERO;
            retry_d = RETRY_ZERO;
          end else if (timer_q == TIMER_ZERO) begin
            state_d = fail_state_s;
            timer_d = fail_timer_s;
            retry_d = fail_retry_s;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_LOCKED: begin
          if (viol_s && (viol_cnt_q != VIOL_SAT)) begin
            viol_cnt_d = viol_cnt_q + VW'(1);
          end else begin
            viol_cnt_d = viol_cnt_q;
          end
          if (!bus.fully_locked_i || (viol_s && (viol_cnt_q == VIOL_LAST))) begin
            state_d = fail_state_s;
            timer_d = fail_timer_s;
            retry_d = fail_retry_s;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        ST_BACKOFF: begin
          if (timer_q == TIMER_ZERO) begin
            state_d    = ST_CLEAR;
            timer_d    = CLEAR_LOAD;
            viol_cnt_d = VIOL_ZERO;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_FAULT: begin
          if (bus.fault_ack_i) begin
            state_d = ST_IDLE;
            retry_d = RETRY_ZERO;
          end else begin
            state_d = ST_FAULT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = TIMER_ZERO;
        end
      endcase
    end
  end

  // Output decode of the next state, so the flopped outputs track state_q exactly.
  always_comb begin
    recovery_en_d = (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
    clear_state_d = (state_d == ST_CLEAR);
    locked_d      = (state_d == ST_LOCKED);
    fault_d       = (state_d == ST_FAULT);
  end

  // State, timer, counters and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= TIMER_ZERO;
      retry_q       <= RETRY_ZERO;
      viol_cnt_q    <= VIOL_ZERO;
      recovery_en_q <= 1'b0;
      clear_state_q <= 1'b0;
      locked_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      viol_cnt_q    <= viol_cnt_d;
      recovery_en_q <= recovery_en_d;
      clear_state_q <= clear_state_d;
      locked_q      <= locked_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.state_o           = state_q;
  assign bus.retry_count_o     = retry_q;
  assign bus.violation_count_o = viol_cnt_q;
  assign bus.recovery_en_o     = recovery_en_q;
  assign bus.clear_state_o     = clear_state_q;
  assign bus.locked_o          = locked_q;
  assign bus.fault_o           = fault_q;

endmodule
